// File: rtl/sts_rx_pkg.sv
// Shared defaults and types for the serial RX deserializer.
package sts_rx_pkg;

   localparam int unsigned DATA_WIDTH_DEF  = 8;
   localparam int unsigned STUFF_LIMIT_DEF = 6;

   typedef logic [DATA_WIDTH_DEF-1:0] rx_word_t;

endpackage

// File: rtl/sts_rx_shift_core.sv
// Bit-level front end: de-stuffs the strobed serial stream and assembles words LSB first.
// Reports the word being completed this cycle; the top level owns the holding register.
module sts_rx_shift_core
   import sts_rx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int unsigned STUFF_LIMIT = STUFF_LIMIT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  serial_in,
   input  logic                  shift,
   input  logic                  clear,
   output logic                  word_done,
   output logic                  stuff_bit,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] word
);

   localparam int unsigned CntW  = $clog2(DATA_WIDTH);
   localparam int unsigned OnesW = $clog2(STUFF_LIMIT + 1);

   localparam logic [CntW-1:0]  LastCnt  = CntW'(DATA_WIDTH - 1);
   localparam logic [OnesW-1:0] StuffCnt = OnesW'(STUFF_LIMIT);

   logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
   logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [OnesW-1:0]      ones_cnt_q, ones_cnt_d;
   logic                  data_bit;

   // Classify the strobed bit and compute next shift/count state (clear wins, then stuff).
   always_comb begin
      stuff_bit   = shift && !clear && (ones_cnt_q == StuffCnt);
      data_bit    = shift && !clear && !stuff_bit;
      word        = {serial_in, shift_reg_q[DATA_WIDTH-1:1]};
      word_done   = data_bit && (bit_cnt_q == LastCnt);
      shift_reg_d = shift_reg_q;
      bit_cnt_d   = bit_cnt_q;
      ones_cnt_d  = ones_cnt_q;
      if (clear) begin
         shift_reg_d = '0;
         bit_cnt_d   = '0;
         ones_cnt_d  = '0;
      end else if (stuff_bit) begin
         // Stuff bit is dropped; only the run-length counter restarts.
         ones_cnt_d = '0;
      end else if (data_bit) begin
         shift_reg_d = word;
         // Run length spans word boundaries, matching the transmitter.
         ones_cnt_d  = serial_in ? ones_cnt_q + OnesW'(1) : '0;
         bit_cnt_d   = word_done ? '0 : bit_cnt_q + CntW'(1);
      end
   end

   // Shift register and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg_q <= '0;
         bit_cnt_q   <= '0;
         ones_cnt_q  <= '0;
      end else begin
         shift_reg_q <= shift_reg_d;
         bit_cnt_q   <= bit_cnt_d;
         ones_cnt_q  <= ones_cnt_d;
      end
   end

   assign busy = (bit_cnt_q != '0);

endmodule

// File: rtl/sts_rx_deserializer.sv
// RX deserializer top: de-stuffing shift core plus a one-entry valid/ready holding register.
// Raises one-cycle pulses for dropped words (overrun) and a 1 seen in a stuff position.
module sts_rx_deserializer
   import sts_rx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int unsigned STUFF_LIMIT = STUFF_LIMIT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  serial_in,
   input  logic                  shift,
   input  logic                  clear,
   input  logic                  rx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  overrun,
   output logic                  stuff_err
);

   logic                  word_done;
   logic                  stuff_bit;
   logic [DATA_WIDTH-1:0] word;
   logic                  load;

   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  overrun_q, overrun_d;
   logic                  stuff_err_q, stuff_err_d;

   sts_rx_shift_core #(
      .DATA_WIDTH  (DATA_WIDTH),
      .STUFF_LIMIT (STUFF_LIMIT)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .serial_in (serial_in),
      .shift     (shift),
      .clear     (clear),
      .word_done (word_done),
      .stuff_bit (stuff_bit),
      .busy      (busy),
      .word      (word)
   );

   // Holding register: accept a new word when empty or draining this cycle, else drop it.
   always_comb begin
      load        = word_done && (!rx_valid_q || rx_ready);
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = word_done && !load;
      stuff_err_d = stuff_bit && serial_in;
      if (load) begin
         rx_data_d  = word;
         rx_valid_d = 1'b1;
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         stuff_err_q <= 1'b0;
      end else begin
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         stuff_err_q <= stuff_err_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign overrun   = overrun_q;
   assign stuff_err = stuff_err_q;

endmodule

// File: tb/tb_sts_rx_deserializer.sv
// Directed bench for sts_rx_deserializer with a queue-based reference model.
module tb_sts_rx_deserializer;

   localparam int W     = 8;
   localparam int LIMIT = 6;

   logic         clk = 1'b0;
   logic         rst;
   logic         serial_in;
   logic         shift;
   logic         clear;
   logic         rx_ready;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         busy;
   logic         overrun;
   logic         stuff_err;

   int err_cnt = 0;
   int chk_cnt = 0;
   bit chk_en  = 1'b0;

   // Reference model: received-but-unpacked data bits, current run of 1s, holding register.
   bit           m_bits[$];
   int           m_ones;
   logic [W-1:0] m_data;
   logic         m_valid;
   logic         m_ovr;
   logic         m_serr;

   sts_rx_deserializer #(
      .DATA_WIDTH  (W),
      .STUFF_LIMIT (LIMIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .serial_in (serial_in),
      .shift     (shift),
      .clear     (clear),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .busy      (busy),
      .overrun   (overrun),
      .stuff_err (stuff_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_ones  = 0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_serr  = 1'b0;
   endtask

   // Apply inputs for one clock, advance the model across the edge, return at edge+1.
   task automatic cyc(input logic s, input logic b, input logic c, input logic r);
      bit           nb[$];
      int           no;
      logic [W-1:0] nd;
      logic [W-1:0] w;
      logic         nv;
      logic         done;
      logic         novr;
      logic         nserr;
      shift     = s;
      serial_in = b;
      clear     = c;
      rx_ready  = r;
      nb    = m_bits;
      no    = m_ones;
      nd    = m_data;
      nv    = m_valid;
      done  = 1'b0;
      novr  = 1'b0;
      nserr = 1'b0;
      w     = '0;
      if (c) begin
         nb.delete();
         no = 0;
      end else if (s) begin
         if (no == LIMIT) begin
            no    = 0;
            nserr = b;
         end else begin
            nb.push_back(b);
            no = b ? no + 1 : 0;
            if (nb.size() == W) begin
               for (int i = 0; i < W; i++) w[i] = nb[i];
               nb.delete();
               done = 1'b1;
            end
         end
      end
      if (done) begin
         if (!nv || r) begin
            nd = w;
            nv = 1'b1;
         end else begin
            novr = 1'b1;
         end
      end else if (nv && r) begin
         nv = 1'b0;
      end
      @(posedge clk);
      m_bits  = nb;
      m_ones  = no;
      m_data  = nd;
      m_valid = nv;
      m_ovr   = novr;
      m_serr  = nserr;
      #1;
   endtask

   // Send n strobed bits, LSB of 'bits' first; rx_ready applied only on the last one.
   task automatic send(input logic [15:0] bits, input int n, input logic r_last);
      for (int i = 0; i < n; i++) cyc(1'b1, bits[i], 1'b0, (i == n - 1) ? r_last : 1'b0);
   endtask

   task automatic idle(input logic r);
      cyc(1'b0, 1'b0, 1'b0, r);
   endtask

   // Every cycle: DUT outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("rx_data", 32'(rx_data), 32'(m_data));
         check("rx_valid", 32'(rx_valid), 32'(m_valid));
         check("busy", 32'(busy), 32'(m_bits.size() != 0));
         check("overrun", 32'(overrun), 32'(m_ovr));
         check("stuff_err", 32'(stuff_err), 32'(m_serr));
      end
   end

   initial begin
      rst       = 1'b1;
      serial_in = 1'b0;
      shift     = 1'b0;
      clear     = 1'b0;
      rx_ready  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      check("reset_data", 32'(rx_data), 32'h0);
      check("reset_valid", 32'(rx_valid), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);

      // 0xA5, held with rx_ready low.
      send(16'h00A5, 8, 1'b0);
      check("a5_data", 32'(rx_data), 32'hA5);
      check("a5_model", 32'(m_data), 32'hA5);
      check("a5_valid", 32'(rx_valid), 32'h1);
      check("a5_busy", 32'(busy), 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      check("a5_drained", 32'(rx_valid), 32'h0);

      // 0xFF with a stuffed 0 after the sixth 1.
      send(16'h01BF, 9, 1'b0);
      check("ff_data", 32'(rx_data), 32'hFF);
      check("ff_model", 32'(m_data), 32'hFF);
      idle(1'b1);
      // Run of two 1s carries over: stuff bit after the 4th bit of this word -> 0x0F.
      send(16'h000F, 9, 1'b0);
      check("0f_data", 32'(rx_data), 32'h0F);
      check("0f_model", 32'(m_data), 32'h0F);
      idle(1'b1);

      // Six 1s then a stuffed 1.
      send(16'h007F, 7, 1'b0);
      check("serr_pulse", 32'(stuff_err), 32'h1);
      check("serr_busy", 32'(busy), 32'h1);
      idle(1'b0);
      check("serr_single", 32'(stuff_err), 32'h0);
      send(16'h0002, 2, 1'b0);
      check("bf_data", 32'(rx_data), 32'hBF);
      idle(1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);

      // Overrun: 0x3C held, 0x5A dropped.
      send(16'h003C, 8, 1'b0);
      send(16'h005A, 8, 1'b0);
      check("ovr_pulse", 32'(overrun), 32'h1);
      check("ovr_data", 32'(rx_data), 32'h3C);
      idle(1'b0);
      check("ovr_single", 32'(overrun), 32'h0);
      // Same word, draining on the completion cycle: replaces the held word.
      send(16'h005A, 8, 1'b1);
      check("drain_data", 32'(rx_data), 32'h5A);
      check("drain_valid", 32'(rx_valid), 32'h1);
      check("drain_no_ovr", 32'(overrun), 32'h0);

      // Clear with a simultaneous strobe discards the partial word only.
      send(16'h0007, 3, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      check("clr_busy", 32'(busy), 32'h0);
      check("clr_data", 32'(rx_data), 32'h5A);
      check("clr_valid", 32'(rx_valid), 32'h1);
      send(16'h0086, 8, 1'b1);
      check("86_data", 32'(rx_data), 32'h86);
      check("86_model", 32'(m_data), 32'h86);

      // Asynchronous reset mid-word with a word held.
      send(16'h0005, 3, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("arst_data", 32'(rx_data), 32'h0);
      check("arst_valid", 32'(rx_valid), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      send(16'h00C3, 8, 1'b0);
      check("c3_data", 32'(rx_data), 32'hC3);
      check("c3_valid", 32'(rx_valid), 32'h1);
      idle(1'b1);
      idle(1'b0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
